// File: rtl/band_autocorr_scheduler.sv
// band_autocorr_scheduler
// Shares one autocorrelation engine across the low/mid/high flux bands.
// Holds an active frame plus one pending frame, issues one band at a time
// over a valid/ready handshake, collects per-band BPM results and forms the
// weighted final BPM estimate.
// Optional WAIT watchdog: define BPM_SCHED_TIMEOUT_EN.
module band_autocorr_scheduler #(
    parameter int W       = 70,
    parameter int BPM_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flux_valid,
    input  logic [W-1:0]     flux_low,
    input  logic [W-1:0]     flux_mid,
    input  logic [W-1:0]     flux_high,
    input  logic             beat_valid,
    output logic             eng_valid,
    input  logic             eng_ready,
    output logic [1:0]       eng_band,
    output logic [W-1:0]     eng_flux,
    output logic             eng_beat,
    input  logic             eng_done,
    input  logic [BPM_W-1:0] eng_bpm,
    output logic [BPM_W-1:0] bpm_low,
    output logic [BPM_W-1:0] bpm_mid,
    output logic [BPM_W-1:0] bpm_high,
    output logic [BPM_W-1:0] final_bpm,
    output logic             final_valid,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMBINE} state_t;

    state_t              state, state_n;
    logic [1:0]          band;
    logic                gap;        // one idle cycle after a no-beat handshake
    logic [2:0][W-1:0]   act_flux, pend_flux, in_flux;
    logic                act_beat, pend_beat, pend_full;
    logic [BPM_W-1:0]    final_q, combine_val;
    logic [20:0]         wsum, prod;
    logic                hs, last_band, leave, promote, load_act;
    logic                done_ev, wd_fire;

    assign in_flux   = {flux_high, flux_mid, flux_low};
    assign hs        = eng_valid & eng_ready;
    assign last_band = (band == 2'd2);
    assign done_ev   = eng_done | wd_fire;
    assign promote   = leave & pend_full;
    assign load_act  = flux_valid & ((state == S_IDLE) | (leave & ~pend_full));

    // Weighted estimate: 7*(2*low + mid + high)/24 at 21-bit unsigned width
    assign wsum        = (21'(bpm_low) << 1) + 21'(bpm_mid) + 21'(bpm_high);
    assign prod        = wsum * 21'd7;
    assign combine_val = BPM_W'(prod / 21'd24);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; a frame ready at exit skips the IDLE cycle
    always_comb begin
        state_n = state;
        leave   = 1'b0;
        case (state)
            S_IDLE:    if (flux_valid) state_n = S_ISSUE;
            S_ISSUE: begin
                if (gap) begin
                    if (last_band) leave = 1'b1;
                end else if (hs && act_beat) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT:    if (done_ev) state_n = last_band ? S_COMBINE : S_ISSUE;
            S_COMBINE: leave = 1'b1;
            default:   state_n = S_IDLE;
        endcase
        if (leave) state_n = (pend_full || flux_valid) ? S_ISSUE : S_IDLE;
    end

    // Output decode
    always_comb begin
        eng_valid   = (state == S_ISSUE) && !gap;
        final_valid = (state == S_COMBINE);
        busy        = (state != S_IDLE);
        final_bpm   = (state == S_COMBINE) ? combine_val : final_q;
        case (band)
            2'd0:    eng_flux = act_flux[0];
            2'd1:    eng_flux = act_flux[1];
            default: eng_flux = act_flux[2];
        endcase
    end

    assign eng_band = band;
    assign eng_beat = act_beat;

    // Band pointer and post-handshake gap flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            band <= 2'd0;
            gap  <= 1'b0;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (gap) begin
                        gap  <= 1'b0;
                        band <= last_band ? 2'd0 : band + 2'd1;
                    end else if (hs && !act_beat) begin
                        gap <= 1'b1;
                    end
                end
                S_WAIT:  if (done_ev && !last_band) band <= band + 2'd1;
                default: begin
                    band <= 2'd0;
                    gap  <= 1'b0;
                end
            endcase
        end
    end

    // Frame slots: promotion first, then direct load, else pending/drop
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_flux  <= '0;
            act_beat  <= 1'b0;
            pend_flux <= '0;
            pend_beat <= 1'b0;
            pend_full <= 1'b0;
            overrun   <= 1'b0;
        end else if (promote) begin
            act_flux <= pend_flux;
            act_beat <= pend_beat;
            if (flux_valid) begin
                pend_flux <= in_flux;
                pend_beat <= beat_valid;
            end else begin
                pend_full <= 1'b0;
            end
        end else if (load_act) begin
            act_flux <= in_flux;
            act_beat <= beat_valid;
        end else if (flux_valid) begin
            if (!pend_full) begin
                pend_flux <= in_flux;
                pend_beat <= beat_valid;
                pend_full <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    // Per-band results; eng_done outside WAIT is ignored
    always_ff @(posedge clk) begin
        if (!reset) begin
            bpm_low  <= '0;
            bpm_mid  <= '0;
            bpm_high <= '0;
        end else if (state == S_WAIT && eng_done) begin
            case (band)
                2'd0:    bpm_low  <= eng_bpm;
                2'd1:    bpm_mid  <= eng_bpm;
                default: bpm_high <= eng_bpm;
            endcase
        end
    end

    // Hold the last estimate between COMBINE cycles
    always_ff @(posedge clk) begin
        if (!reset)                  final_q <= '0;
        else if (state == S_COMBINE) final_q <= combine_val;
    end

`ifdef BPM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    assign wd_fire = (state == S_WAIT) && !eng_done && (wd_cnt == CW'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles without eng_done
    always_ff @(posedge clk) begin
        if (!reset)                            wd_cnt <= '0;
        else if (state == S_WAIT && !eng_done) wd_cnt <= wd_cnt + 1'b1;
        else                                   wd_cnt <= '0;
    end

    // Sticky watchdog flag
    always_ff @(posedge clk) begin
        if (!reset)       timeout_err <= 1'b0;
        else if (wd_fire) timeout_err <= 1'b1;
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign wd_fire        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_band_autocorr_scheduler.sv
// Directed self-checking bench for band_autocorr_scheduler.
// Build with BPM_SCHED_TIMEOUT_EN to exercise the watchdog (TIMEOUT=16).
module tb_band_autocorr_scheduler;
    localparam int W = 70;
    localparam int BPM_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             flux_valid;
    logic [W-1:0]     flux_low, flux_mid, flux_high;
    logic             beat_valid;
    logic             eng_valid;
    logic             eng_ready;
    logic [1:0]       eng_band;
    logic [W-1:0]     eng_flux;
    logic             eng_beat;
    logic             eng_done;
    logic [BPM_W-1:0] eng_bpm;
    logic [BPM_W-1:0] bpm_low, bpm_mid, bpm_high, final_bpm;
    logic             final_valid, busy, overrun, timeout_err;

    int total = 0;
    int passed = 0;

    band_autocorr_scheduler #(.W(W), .BPM_W(BPM_W), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .flux_valid(flux_valid),
        .flux_low(flux_low), .flux_mid(flux_mid), .flux_high(flux_high),
        .beat_valid(beat_valid), .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_band(eng_band), .eng_flux(eng_flux), .eng_beat(eng_beat),
        .eng_done(eng_done), .eng_bpm(eng_bpm), .bpm_low(bpm_low),
        .bpm_mid(bpm_mid), .bpm_high(bpm_high), .final_bpm(final_bpm),
        .final_valid(final_valid), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     fl, fm, fh;
        logic             beat;
        logic [BPM_W-1:0] bl, bm, bh;   // engine replies (or retained values when beat=0)
        logic [BPM_W-1:0] fin;          // expected final_bpm after the frame
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_flux(input logic [W-1:0] l, input logic [W-1:0] m,
                              input logic [W-1:0] h, input logic bt);
        step();
        flux_valid = 1'b1; flux_low = l; flux_mid = m; flux_high = h; beat_valid = bt;
        step();
        flux_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            if (eng_valid) return;
            step();
        end
        check("eng_valid wait", 80'(eng_valid), 80'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            step();
        end
        check("idle wait", 80'(busy), 80'd0);
    endtask

    // Accept one band job; for beat frames return bp two cycles after handshake
    task automatic serve_band(input int b, input logic [W-1:0] fx, input logic bt,
                              input logic [BPM_W-1:0] bp);
        wait_valid();
        check($sformatf("band%0d id", b), 80'(eng_band), 80'(b));
        check($sformatf("band%0d flux", b), 80'(eng_flux), 80'(fx));
        check($sformatf("band%0d beat", b), 80'(eng_beat), 80'(bt));
        step();
        check($sformatf("band%0d drop after hs", b), 80'(eng_valid), 80'd0);
        if (bt) begin
            step();
            eng_done = 1'b1; eng_bpm = bp;
            step();
            eng_done = 1'b0;
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        bit saw;
        drive_flux(v.fl, v.fm, v.fh, v.beat);
        serve_band(0, v.fl, v.beat, v.bl);
        serve_band(1, v.fm, v.beat, v.bm);
        serve_band(2, v.fh, v.beat, v.bh);
        if (v.beat) begin
            check($sformatf("vec%0d final_valid", idx), 80'(final_valid), 80'd1);
            check($sformatf("vec%0d final_bpm", idx), 80'(final_bpm), 80'(v.fin));
            step();
            check($sformatf("vec%0d final pulse end", idx), 80'(final_valid), 80'd0);
        end else begin
            saw = 0;
            for (int i = 0; i < 20 && busy; i++) begin
                if (final_valid) saw = 1;
                step();
            end
            check($sformatf("vec%0d no final", idx), 80'(saw), 80'd0);
        end
        wait_idle();
        check($sformatf("vec%0d held final", idx), 80'(final_bpm), 80'(v.fin));
        check($sformatf("vec%0d bands", idx), 80'({bpm_low, bpm_mid, bpm_high}),
              80'({v.bl, v.bm, v.bh}));
    endtask

    initial begin
        int nb, nh, cnt, n, bad;
        logic [W-1:0] got[8];

        tbl[0] = '{fl: 70'd1, fm: 70'd2, fh: 70'd3, beat: 1'b1,
                   bl: 16'd120, bm: 16'd60, bh: 16'd180, fin: 16'd140};
        tbl[1] = '{fl: 70'h3F_FFFF_FFFF_FFFF_FFFF, fm: 70'h20_0000_0000_0000_0001, fh: 70'd0,
                   beat: 1'b1, bl: 16'd100, bm: 16'd100, bh: 16'd100, fin: 16'd116};
        tbl[2] = '{fl: 70'd5, fm: 70'd6, fh: 70'd7, beat: 1'b1,
                   bl: 16'd0, bm: 16'd0, bh: 16'd0, fin: 16'd0};
        tbl[3] = '{fl: 70'd8, fm: 70'd9, fh: 70'd10, beat: 1'b1,
                   bl: 16'd3, bm: 16'd2, bh: 16'd1, fin: 16'd2};
        tbl[4] = '{fl: 70'd11, fm: 70'd12, fh: 70'd13, beat: 1'b1,
                   bl: 16'd9000, bm: 16'd9000, bh: 16'd9000, fin: 16'd10500};
        tbl[5] = '{fl: 70'd14, fm: 70'd15, fh: 70'd16, beat: 1'b1,
                   bl: 16'd1, bm: 16'd2, bh: 16'd0, fin: 16'd1};
        tbl[6] = '{fl: 70'd17, fm: 70'd18, fh: 70'd19, beat: 1'b0,
                   bl: 16'd1, bm: 16'd2, bh: 16'd0, fin: 16'd1};

        reset = 1'b0; flux_valid = 1'b0; beat_valid = 1'b0; eng_ready = 1'b1;
        eng_done = 1'b0; eng_bpm = '0; flux_low = '0; flux_mid = '0; flux_high = '0;

        // Power-on reset
        repeat (3) step();
        check("rst eng_valid", 80'(eng_valid), 80'd0);
        check("rst busy", 80'(busy), 80'd0);
        check("rst outputs", 80'({final_bpm, bpm_low, bpm_mid, bpm_high, final_valid,
                                  overrun, timeout_err}), 80'd0);
        reset = 1'b1;

        // No-beat frame: three handshakes, busy 6 cycles
        drive_flux(70'd10, 70'd20, 70'd30, 1'b0);
        nb = 0; nh = 0; bad = 0;
        for (int i = 0; i < 50 && busy; i++) begin
            nb++;
            if (final_valid) bad++;
            if (eng_valid && eng_ready) begin
                check($sformatf("nobeat hs%0d band", nh), 80'(eng_band), 80'(nh));
                check($sformatf("nobeat hs%0d flux", nh), 80'(eng_flux), 80'(nh * 10 + 10));
                nh++;
            end
            step();
        end
        check("nobeat busy cycles", 80'(nb), 80'd6);
        check("nobeat handshakes", 80'(nh), 80'd3);
        check("nobeat no final", 80'(bad), 80'd0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) run_frame(i, tbl[i]);

        // Band 1 never completes
        drive_flux(70'd50, 70'd51, 70'd52, 1'b1);
        serve_band(0, 70'd50, 1'b1, 16'd50);
        wait_valid();
        check("to band1 issued", 80'(eng_band), 80'd1);
        step();
        check("to err before", 80'(timeout_err), 80'd0);
`ifdef BPM_SCHED_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 40 && !eng_valid; i++) begin
            step();
            cnt++;
        end
        check("to cycles", 80'(cnt), 80'd16);
        check("to err set", 80'(timeout_err), 80'd1);
        check("to bpm_mid kept", 80'(bpm_mid), 80'd2);
        check("to next band", 80'(eng_band), 80'd2);
`else
        repeat (20) step();
        check("hold wait", 80'({eng_valid, busy, timeout_err}), 80'b010);
        eng_done = 1'b1; eng_bpm = 16'd2;
        step();
        eng_done = 1'b0;
`endif
        serve_band(2, 70'd52, 1'b1, 16'd30);
        check("to final_valid", 80'(final_valid), 80'd1);
        check("to final_bpm", 80'(final_bpm), 80'd38);
        wait_idle();

        // Backpressure: payload held for 5 cycles
        eng_ready = 1'b0;
        drive_flux(70'd40, 70'd41, 70'd42, 1'b0);
        check("bp valid", 80'(eng_valid), 80'd1);
        bad = 0;
        repeat (5) begin
            step();
            if (!(eng_valid && eng_band == 2'd0 && eng_flux == 70'd40 && !eng_beat)) bad++;
        end
        check("bp hold", 80'(bad), 80'd0);
        eng_ready = 1'b1;
        step();
        check("bp handshake", 80'(eng_valid), 80'd0);
        wait_idle();

        // New frame arriving in COMBINE goes next
        drive_flux(70'd31, 70'd32, 70'd33, 1'b1);
        serve_band(0, 70'd31, 1'b1, 16'd120);
        serve_band(1, 70'd32, 1'b1, 16'd60);
        serve_band(2, 70'd33, 1'b1, 16'd180);
        flux_valid = 1'b1; flux_low = 70'd21; flux_mid = 70'd22; flux_high = 70'd23;
        beat_valid = 1'b0;
        check("sim final_valid", 80'(final_valid), 80'd1);
        check("sim final_bpm", 80'(final_bpm), 80'd140);
        step();
        flux_valid = 1'b0;
        check("sim next issue", 80'({eng_valid, busy, eng_band}), 80'b1100);
        check("sim next flux", 80'(eng_flux), 80'd21);
        check("sim no overrun", 80'(overrun), 80'd0);
        wait_idle();

        // Overrun: second frame pending, third dropped
        eng_ready = 1'b0;
        drive_flux(70'd1, 70'd2, 70'd3, 1'b0);
        drive_flux(70'd4, 70'd5, 70'd6, 1'b0);
        check("ovr clear", 80'(overrun), 80'd0);
        drive_flux(70'd7, 70'd8, 70'd9, 1'b0);
        check("ovr set", 80'(overrun), 80'd1);
        eng_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            if (eng_valid && n < 8) begin
                got[n] = eng_flux;
                n++;
            end
            step();
        end
        check("ovr job count", 80'(n), 80'd6);
        for (int k = 0; k < 6; k++) check($sformatf("ovr job%0d flux", k), 80'(got[k]), 80'(k + 1));

        // Reset mid-WAIT
        drive_flux(70'd60, 70'd61, 70'd62, 1'b1);
        wait_valid();
        step();
        check("mid wait", 80'({eng_valid, busy}), 80'b01);
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst2 eng", 80'({eng_valid, eng_band, eng_beat}), 80'd0);
        check("rst2 eng_flux", 80'(eng_flux), 80'd0);
        check("rst2 state", 80'({busy, final_valid, overrun, timeout_err}), 80'd0);
        check("rst2 bpm", 80'({final_bpm, bpm_low, bpm_mid, bpm_high}), 80'd0);

        // eng_done outside WAIT is ignored
        eng_done = 1'b1; eng_bpm = 16'd999;
        step();
        eng_done = 1'b0;
        step();
        check("stray done", 80'({bpm_low, bpm_mid, bpm_high, busy}), 80'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
